// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants, state encoding and funct3 decode helpers for the
// RV32M multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // All divide/remainder codes have funct3[2] set.
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic f3_rs1_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            default:                            s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic f3_rs2_signed(input logic [2:0] f3);
        logic s;
        case (f3)
            F3_MULH, F3_DIV, F3_REM: s = 1'b1;
            default:                 s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned core: a shift-add multiply step or a
// restoring-divide step on a 64-bit accumulator.
//   multiply: acc = {partial_hi, multiplier_remaining}, shifts right
//   divide:   acc = {remainder, dividend/quotient},     shifts left
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] sum_s;
    logic [XLEN:0] rem_shift_s;
    logic [XLEN:0] diff_s;

    // Single-iteration datapath for both operations.
    always_comb begin
        sum_s       = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        rem_shift_s = acc[2*XLEN-1:XLEN-1];
        diff_s      = rem_shift_s - {1'b0, operand};
        acc_next    = acc;
        if (is_div) begin
            // Trial subtract succeeded when the 33-bit difference is non-negative.
            if (!diff_s[XLEN]) begin
                acc_next = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum_s, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for RV32M: captures operands, runs 32 unsigned
// iterations on magnitudes, applies sign fix-up and presents the result
// for one cycle while stalling the front of the pipeline meanwhile.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            Start_i,
    input  logic [2:0]      Funct3_i,
    input  logic [XLEN-1:0] RS1data_i,
    input  logic [XLEN-1:0] RS2data_i,
    input  logic            Flush_i,
    output logic            Stall_o,
    output logic            Done_o,
    output logic [XLEN-1:0] Result_o,
    output logic            Busy_o
);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_r, next_state_s;
    logic [4:0]        cnt_r;
    logic [2:0]        funct3_r;
    logic [XLEN-1:0]   operand_r;
    logic [2*XLEN-1:0] acc_r;
    logic              neg_res_r;
    logic              neg_rem_r;
    logic [XLEN-1:0]   result_r;
    logic              done_r;
    logic              busy_r;

    logic              capture_s;
    logic              special_s;
    logic              rs1_neg_s, rs2_neg_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic              div_zero_s, div_ovf_s;
    logic [XLEN-1:0]   special_res_s;
    logic [2*XLEN-1:0] step_acc_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]   final_res_s;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (f3_is_div(funct3_r)),
        .acc      (acc_r),
        .operand  (operand_r),
        .acc_next (step_acc_s)
    );

    // Operand magnitudes, sign flags and special-case detection for the capture cycle.
    always_comb begin
        rs1_neg_s  = f3_rs1_signed(Funct3_i) & RS1data_i[XLEN-1];
        rs2_neg_s  = f3_rs2_signed(Funct3_i) & RS2data_i[XLEN-1];
        mag1_s     = rs1_neg_s ? (-RS1data_i) : RS1data_i;
        mag2_s     = rs2_neg_s ? (-RS2data_i) : RS2data_i;
        div_zero_s = f3_is_div(Funct3_i) && (RS2data_i == ZERO);
        div_ovf_s  = ((Funct3_i == F3_DIV) || (Funct3_i == F3_REM)) &&
                     (RS1data_i == MIN_NEG) && (RS2data_i == ALL_ONES);
        special_s  = div_zero_s | div_ovf_s;
        case (Funct3_i)
            F3_DIV, F3_DIVU: special_res_s = div_zero_s ? ALL_ONES : MIN_NEG;
            F3_REM, F3_REMU: special_res_s = div_zero_s ? RS1data_i : ZERO;
            default:         special_res_s = ZERO;
        endcase
    end

    // Sign fix-up and result selection from the last iteration's accumulator.
    always_comb begin
        prod_s = neg_res_r ? (-step_acc_s) : step_acc_s;
        quo_s  = neg_res_r ? (-step_acc_s[XLEN-1:0]) : step_acc_s[XLEN-1:0];
        rem_s  = neg_rem_r ? (-step_acc_s[2*XLEN-1:XLEN]) : step_acc_s[2*XLEN-1:XLEN];
        case (funct3_r)
            F3_MUL:                       final_res_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: final_res_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              final_res_s = quo_s;
            F3_REM, F3_REMU:              final_res_s = rem_s;
            default:                      final_res_s = ZERO;
        endcase
    end

    // Next-state logic; a flush overrides every state.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        if (Flush_i) begin
            next_state_s = MD_IDLE;
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (Start_i) begin
                        capture_s    = 1'b1;
                        next_state_s = special_s ? MD_DONE : MD_RUN;
                    end else begin
                        next_state_s = MD_IDLE;
                    end
                end
                MD_RUN: begin
                    if (cnt_r == 5'd31) begin
                        next_state_s = MD_DONE;
                    end else begin
                        next_state_s = MD_RUN;
                    end
                end
                MD_DONE: next_state_s = MD_IDLE;
                default: next_state_s = MD_IDLE;
            endcase
        end
    end

    // State, counter, operand/accumulator and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= MD_IDLE;
            cnt_r     <= 5'd0;
            funct3_r  <= 3'b000;
            operand_r <= ZERO;
            acc_r     <= {(2*XLEN){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            result_r  <= ZERO;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= (next_state_s == MD_DONE);
            busy_r  <= (next_state_s != MD_IDLE);
            if (capture_s) begin
                funct3_r  <= Funct3_i;
                operand_r <= mag2_s;
                acc_r     <= {ZERO, mag1_s};
                neg_res_r <= rs1_neg_s ^ rs2_neg_s;
                neg_rem_r <= rs1_neg_s;
                cnt_r     <= 5'd0;
                if (special_s) begin
                    result_r <= special_res_s;
                end
            end else if (Flush_i) begin
                cnt_r <= 5'd0;
            end else if (state_r == MD_RUN) begin
                acc_r <= step_acc_s;
                cnt_r <= cnt_r + 5'd1;
                if (cnt_r == 5'd31) begin
                    result_r <= final_res_s;
                end
            end
        end
    end

    // The stall must act in the capture cycle itself, so it stays combinational.
    assign Stall_o  = ((state_r == MD_IDLE) && Start_i && !Flush_i) ||
                      ((state_r == MD_RUN) && !Flush_i);
    assign Done_o   = done_r;
    assign Result_o = result_r;
    assign Busy_o   = busy_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table,
// randomized ops against an arithmetic reference model, and hand-written
// flush / back-to-back / mid-run reset sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2;
    logic        flush;
    logic        stall, done, busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .Start_i   (start),
        .Funct3_i  (f3),
        .RS1data_i (rs1),
        .RS2data_i (rs2),
        .Flush_i   (flush),
        .Stall_o   (stall),
        .Done_o    (done),
        .Result_o  (result),
        .Busy_o    (busy)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa, sb, p;
        logic ovf;
        sa  = (op == 3'd1 || op == 3'd2) ? {{34{a[31]}}, a} : {34'd0, a};
        sb  = (op == 3'd1) ? {{34{b[31]}}, b} : {34'd0, b};
        p   = sa * sb;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0:       return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (ovf) return 32'h8000_0000;
                else return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op from the current low phase; inputs are scrambled after capture.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls);
        res    = 32'd0;
        lat    = -1;
        stalls = 0;
        start  = 1'b1;
        f3     = op;
        rs1    = a;
        rs2    = b;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall) stalls++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            f3    = 3'($urandom_range(0, 7));
            rs1   = $urandom;
            rs2   = $urandom;
        end
        start = 1'b0;
        if (lat < 0) begin
            errors++;
            checks++;
            $display("FAIL timeout op=%0d actual=no_done required=done", op);
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        int lat, stalls;
        run_op(op, a, b, res, lat, stalls);
        check({name, "_result"}, res, exp);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_stalls"}, 32'(stalls), 32'(exp_lat));
        @(negedge clk);
        #1;
        check({name, "_hold"}, result, exp);
        check({name, "_done_low"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] r1, r2;
        int pulses, c1, c2;
        logic [2:0]  op;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd0, 32'd0,          32'h1234_5678, 32'd0,         33};

        rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall",  {31'd0, stall}, 32'd0);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_result", result,         32'd0);
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), op, a, b, model(op, a, b), model_lat(op, a, b));
        end

        // Flush at RUN counter=10, then a fresh op two cycles later
        start = 1'b1; f3 = 3'd0; rs1 = 32'd123; rs2 = 32'd456;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy_after", {31'd0, busy}, 32'd0);
        check("flush_no_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        #1;
        check("flush_no_done2", {31'd0, done}, 32'd0);
        @(negedge clk);
        do_op("after_flush", 3'd0, 32'd123, 32'd456, 32'd56088, 33);

        // Two back-to-back MULs with Start held through DONE
        start = 1'b1; f3 = 3'd0; rs1 = 32'd1000; rs2 = 32'd3;
        pulses = 0; c1 = -1; c2 = -1; r1 = 32'd0; r2 = 32'd0;
        for (int c = 0; c < 68; c++) begin
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin c1 = c; r1 = result; end
                else begin c2 = c; r2 = result; end
            end
            @(posedge clk); @(negedge clk);
            if (c == 33) begin rs1 = 32'd77; rs2 = 32'hFFFF_FFFF; end
        end
        start = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd2);
        check("b2b_first_cycle", 32'(c1), 32'd33);
        check("b2b_gap", 32'(c2 - c1), 32'd34);
        check("b2b_result1", r1, 32'd3000);
        check("b2b_result2", r2, 32'hFFFF_FFB3);
        @(negedge clk);

        // Synchronous reset in the middle of a run
        start = 1'b1; f3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk); @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_stall",  {31'd0, stall}, 32'd0);
        check("midrst_done",   {31'd0, done},  32'd0);
        check("midrst_busy",   {31'd0, busy},  32'd0);
        check("midrst_result", result,         32'd0);
        @(negedge clk);
        do_op("after_reset", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV32M multiply/divide instructions in the EX stage of the 5-stage pipeline. When EX holds an M-extension op (opcode OP, funct7 0000001), it captures the operands and runs a 32-iteration shift-add multiply or restoring divide. It holds the pipeline with a stall for the whole run, then presents the 32-bit result for one cycle so EX/MEM latches it like an ordinary ALU result.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- Start_i  in  1  EX holds a valid M-extension op (decoder gated by NoOp)
- Funct3_i  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- RS1data_i  in  XLEN  forwarded rs1 value
- RS2data_i  in  XLEN  forwarded rs2 value
- Flush_i  in  1  abort the current op (EX flush)
- Stall_o  out  1  hold PC, IF/ID and ID/EX
- Done_o  out  1  one-cycle pulse: Result_o valid
- Result_o  out  XLEN  result, registered
- Busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start_i=1 captures funct3, the operand magnitudes and the sign flags.
  - Sign flags: rs1 signed for MULH, MULHSU, DIV, REM; rs2 signed for MULH, DIV, REM.
  - Next state is RUN with counter=0, or DONE directly on a special case.
- Special cases, decided in the IDLE capture cycle:
  - divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU result = rs1.
  - DIV overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV 0x80000000, REM 0.
- RUN:
  - Multiply: one shift-add step per cycle into a 64-bit accumulator.
  - Divide: one restoring step per cycle (remainder shift, trial subtract, quotient bit).
  - The counter increments each cycle; at counter=31 the state goes to DONE and Result_o is loaded.
- Result selection:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Product sign: negate the 64-bit product iff (rs1 negative and signed) xor (rs2 negative and signed).
  - Quotient is negated iff the signed operand signs differ; remainder takes the sign of rs1.
  - MUL ignores signs (low word is sign-agnostic).
- DONE:
  - Done_o=1 and Stall_o=0, so the pipeline advances with the same instruction.
  - Start_i in DONE is ignored (it is still the completed op); next state is IDLE.
- Flush_i has priority over everything: next state IDLE, Done_o is not produced, Stall_o=0 in the flush cycle.
- Operand registers are not updated outside the IDLE capture cycle; input changes during RUN are ignored.

## Timing
- Reset: state IDLE, counter 0, Stall_o 0, Done_o 0, Busy_o 0, Result_o 0, internal registers 0.
- Stall_o = (IDLE and Start_i and not Flush_i) or (RUN and not Flush_i).
  - This is a combinational path from Start_i, so the pipeline freezes in the capture cycle itself.
- Normal op:
  - capture at cycle 0, RUN cycles 1–32, DONE at cycle 33.
  - Stall_o is high for exactly 33 cycles; Done_o is high in cycle 33 only.
- Special case: capture at cycle 0, DONE at cycle 1; Stall_o high for 1 cycle.
- Back-to-back ops: a new Start_i is accepted at the earliest in the cycle after DONE (IDLE).
- Done_o and Result_o are registered; Result_o holds its value until the next DONE.
- Reset mid-RUN returns to the reset values on the next edge.

## Structure
- Const.v additions:
  - FUNCT7_MULDIV.
  - The eight MULDIV funct3 codes.
  - The MULDIV state encodings (2 bits).
- One natural sub-module, muldiv_step: combinational single-iteration logic covering the shift-add step and the restoring-divide step, selected by an is_div flag.
- The sequencer holds the FSM, counter, operand and accumulator registers, sign fix-up and result mux.

## Test plan
- MUL 7 × −3 → Result_o 0xFFFFFFEB; Stall_o high 33 cycles; Done_o in cycle 33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU −1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases, each with Done_o at cycle 1:
  - DIVU 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000.
- Flush_i pulsed at RUN counter=10 → IDLE next cycle, no Done_o, Stall_o 0; a new Start_i two cycles later completes correctly.
- Two back-to-back MULs with Start_i held through DONE → exactly two Done_o pulses, 34 cycles apart; rst_i mid-RUN → all outputs 0 next cycle.
